// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive checker for the 3-bit {red, yellow, green} lights bus. It decodes
// the bus back into a phase, checks that the lights are one-hot and that the
// phases follow GREEN -> YELLOW -> RED -> GREEN, flags phases held for too
// long and counts completed light cycles. It only observes the bus.
//
// Parameters:
//   MAX_DWELL   maximum consecutive samples allowed in one phase (1..255)
//   CNT_W       width of cycle_count
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   en           sample enable; when low only err_clr acts
//   lights       observed bus {R,Y,G}
//   err_clr      synchronous clear of the sticky error flags
//   phase        decoded phase: 00 GREEN, 01 YELLOW, 10 RED, 11 UNKNOWN
//   synced       monitor locked onto a valid phase
//   cycle_count  completed RED->GREEN transitions, wraps modulo 2^CNT_W
//   err_onehot   sticky: illegal encoding seen
//   err_order    sticky: illegal phase transition seen
//   err_stall    sticky: dwell exceeded MAX_DWELL
//   err_any      OR of the three sticky flags
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int unsigned MAX_DWELL = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       lights,
    input  logic             err_clr,
    output logic [1:0]       phase,
    output logic             synced,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err_onehot,
    output logic             err_order,
    output logic             err_stall,
    output logic             err_any
);

    // Dwell must be able to hold MAX_DWELL+1, the saturated "stalled" value.
    localparam int unsigned DWELL_W = $clog2(MAX_DWELL + 2);

    localparam logic [DWELL_W-1:0] DWELL_ZERO  = DWELL_W'(0);
    localparam logic [DWELL_W-1:0] DWELL_ONE   = DWELL_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_LIMIT = DWELL_W'(MAX_DWELL);
    localparam logic [DWELL_W-1:0] DWELL_SAT   = DWELL_W'(MAX_DWELL + 1);

    localparam logic [1:0] PH_GREEN   = 2'b00;
    localparam logic [1:0] PH_YELLOW  = 2'b01;
    localparam logic [1:0] PH_RED     = 2'b10;
    localparam logic [1:0] PH_UNKNOWN = 2'b11;

    typedef enum logic [0:0] {
        ST_UNSYNC = 1'b0,
        ST_TRACK  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // True only for the three one-hot encodings the light controller may drive.
    function automatic logic lights_valid(input logic [2:0] l);
        logic ok;
        case (l)
            3'b001:  ok = 1'b1;
            3'b010:  ok = 1'b1;
            3'b100:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Map a bus value to its phase code; invalid values map to UNKNOWN.
    function automatic logic [1:0] lights_decode(input logic [2:0] l);
        logic [1:0] ph;
        case (l)
            3'b001:  ph = PH_GREEN;
            3'b010:  ph = PH_YELLOW;
            3'b100:  ph = PH_RED;
            default: ph = PH_UNKNOWN;
        endcase
        return ph;
    endfunction

    // The only legal successor of each phase in the light sequence.
    function automatic logic [1:0] phase_successor(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_GREEN:  nxt = PH_YELLOW;
            PH_YELLOW: nxt = PH_RED;
            PH_RED:    nxt = PH_GREEN;
            default:   nxt = PH_UNKNOWN;
        endcase
        return nxt;
    endfunction

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         phase_r;
    logic [1:0]         phase_nxt_s;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] dwell_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               onehot_r;
    logic               onehot_nxt_s;
    logic               order_r;
    logic               order_nxt_s;
    logic               stall_r;
    logic               stall_nxt_s;
    logic               set_onehot_s;
    logic               set_order_s;
    logic               set_stall_s;
    logic               valid_s;
    logic [1:0]         dec_s;

    assign valid_s = lights_valid(lights);
    assign dec_s   = lights_decode(lights);

    // -------------------------------------------------------------------------
    // State register: FSM state plus all tracked/sticky registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_UNSYNC;
            phase_r  <= PH_UNKNOWN;
            dwell_r  <= DWELL_ZERO;
            cnt_r    <= '0;
            onehot_r <= 1'b0;
            order_r  <= 1'b0;
            stall_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            phase_r  <= phase_nxt_s;
            dwell_r  <= dwell_nxt_s;
            cnt_r    <= cnt_nxt_s;
            onehot_r <= onehot_nxt_s;
            order_r  <= order_nxt_s;
            stall_r  <= stall_nxt_s;
        end
    end

    // Next-state logic: lock on any valid sample, drop lock on any invalid one.
    always_comb begin
        state_nxt_s = state_r;
        if (en) begin
            case (state_r)
                ST_UNSYNC: begin
                    if (valid_s) begin
                        state_nxt_s = ST_TRACK;
                    end else begin
                        state_nxt_s = ST_UNSYNC;
                    end
                end
                ST_TRACK: begin
                    if (valid_s) begin
                        state_nxt_s = ST_TRACK;
                    end else begin
                        state_nxt_s = ST_UNSYNC;
                    end
                end
                default: state_nxt_s = ST_UNSYNC;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output logic: phase/dwell/count updates and error events for this sample.
    always_comb begin
        phase_nxt_s  = phase_r;
        dwell_nxt_s  = dwell_r;
        cnt_nxt_s    = cnt_r;
        set_onehot_s = 1'b0;
        set_order_s  = 1'b0;
        set_stall_s  = 1'b0;
        if (en) begin
            case (state_r)
                ST_UNSYNC: begin
                    // Locking on never counts a cycle nor judges the order.
                    if (valid_s) begin
                        phase_nxt_s = dec_s;
                        dwell_nxt_s = DWELL_ONE;
                    end else begin
                        set_onehot_s = 1'b1;
                        phase_nxt_s  = PH_UNKNOWN;
                        dwell_nxt_s  = DWELL_ZERO;
                    end
                end
                ST_TRACK: begin
                    if (!valid_s) begin
                        set_onehot_s = 1'b1;
                        phase_nxt_s  = PH_UNKNOWN;
                        dwell_nxt_s  = DWELL_ZERO;
                    end else if (dec_s == phase_r) begin
                        // Saturate so a long stall raises exactly one event.
                        if (dwell_r < DWELL_SAT) begin
                            dwell_nxt_s = dwell_r + DWELL_ONE;
                        end else begin
                            dwell_nxt_s = dwell_r;
                        end
                        if (dwell_r == DWELL_LIMIT) begin
                            set_stall_s = 1'b1;
                        end else begin
                            set_stall_s = 1'b0;
                        end
                    end else if (dec_s == phase_successor(phase_r)) begin
                        phase_nxt_s = dec_s;
                        dwell_nxt_s = DWELL_ONE;
                        if (phase_r == PH_RED) begin
                            cnt_nxt_s = cnt_r + CNT_W'(1);
                        end else begin
                            cnt_nxt_s = cnt_r;
                        end
                    end else begin
                        // Out-of-order jump: flag it and resync on the new phase.
                        set_order_s = 1'b1;
                        phase_nxt_s = dec_s;
                        dwell_nxt_s = DWELL_ONE;
                    end
                end
                default: begin
                    phase_nxt_s = PH_UNKNOWN;
                    dwell_nxt_s = DWELL_ZERO;
                end
            endcase
        end else begin
            phase_nxt_s = phase_r;
            dwell_nxt_s = dwell_r;
            cnt_nxt_s   = cnt_r;
        end

        // A new event wins over a clear arriving on the same edge.
        onehot_nxt_s = (onehot_r & ~err_clr) | set_onehot_s;
        order_nxt_s  = (order_r  & ~err_clr) | set_order_s;
        stall_nxt_s  = (stall_r  & ~err_clr) | set_stall_s;
    end

    assign phase       = phase_r;
    assign synced      = (state_r == ST_TRACK);
    assign cycle_count = cnt_r;
    assign err_onehot  = onehot_r;
    assign err_order   = order_r;
    assign err_stall   = stall_r;
    assign err_any     = onehot_r | order_r | stall_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Directed bench for traffic_light_monitor. Two instances share the stimulus:
// dut_a uses the default parameters (MAX_DWELL=4, CNT_W=8) and dut_w uses
// CNT_W=2 to observe counter wrap. A vector table covers the per-sample
// behaviour; hand-written sequences cover wrap and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] lights;
    logic       err_clr;

    logic [1:0] a_phase;
    logic       a_synced;
    logic [7:0] a_cnt;
    logic       a_onehot, a_order, a_stall, a_any;

    logic [1:0] w_phase;
    logic       w_synced;
    logic [1:0] w_cnt;
    logic       w_onehot, w_order, w_stall, w_any;

    int checks   = 0;
    int failures = 0;

    traffic_light_monitor #(.MAX_DWELL(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .lights(lights), .err_clr(err_clr),
        .phase(a_phase), .synced(a_synced), .cycle_count(a_cnt),
        .err_onehot(a_onehot), .err_order(a_order), .err_stall(a_stall),
        .err_any(a_any)
    );

    traffic_light_monitor #(.MAX_DWELL(4), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .en(en), .lights(lights), .err_clr(err_clr),
        .phase(w_phase), .synced(w_synced), .cycle_count(w_cnt),
        .err_onehot(w_onehot), .err_order(w_order), .err_stall(w_stall),
        .err_any(w_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] lights;
        logic       en;
        logic       clr;
        logic [1:0] ph;
        logic       sy;
        logic [7:0] cnt;
        logic       oh;
        logic       od;
        logic       st;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [2:0] l, input logic e, input logic c,
                       input logic [1:0] ph, input logic sy, input logic [7:0] cnt,
                       input logic oh, input logic od, input logic st);
        vec_t v;
        v.lights = l; v.en = e; v.clr = c; v.ph = ph; v.sy = sy;
        v.cnt = cnt; v.oh = oh; v.od = od; v.st = st;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output of dut_a, plus the 2-bit counter and phase of dut_w.
    task automatic check_all(input string tag, input logic [1:0] ph, input logic sy,
                             input logic [7:0] cnt, input logic oh, input logic od,
                             input logic st);
        chk({tag, " phase"},   32'(a_phase),  32'(ph));
        chk({tag, " synced"},  32'(a_synced), 32'(sy));
        chk({tag, " count"},   32'(a_cnt),    32'(cnt));
        chk({tag, " onehot"},  32'(a_onehot), 32'(oh));
        chk({tag, " order"},   32'(a_order),  32'(od));
        chk({tag, " stall"},   32'(a_stall),  32'(st));
        chk({tag, " any"},     32'(a_any),    32'(oh | od | st));
        chk({tag, " w_count"}, 32'(w_cnt),    32'(cnt[1:0]));
        chk({tag, " w_phase"}, 32'(w_phase),  32'(ph));
    endtask

    task automatic step(input logic [2:0] l, input logic e, input logic c);
        lights  = l;
        en      = e;
        err_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; lights = 3'b000; err_clr = 1'b0;

        //  lights  en    clr   phase  sy    cnt    oh    od    st
        // nominal run
        add(3'b100, 1'b1, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        add(3'b001, 1'b1, 1'b0, 2'b00, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        add(3'b010, 1'b1, 1'b0, 2'b01, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        add(3'b100, 1'b1, 1'b0, 2'b10, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        add(3'b001, 1'b1, 1'b0, 2'b00, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        add(3'b010, 1'b1, 1'b0, 2'b01, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        add(3'b100, 1'b1, 1'b0, 2'b10, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        add(3'b001, 1'b1, 1'b0, 2'b00, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        // green held: samples 2..4 fine, 5th raises stall, 6th saturates
        add(3'b001, 1'b1, 1'b0, 2'b00, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        add(3'b001, 1'b1, 1'b0, 2'b00, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        add(3'b001, 1'b1, 1'b0, 2'b00, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        add(3'b001, 1'b1, 1'b0, 2'b00, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1);
        add(3'b001, 1'b1, 1'b0, 2'b00, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1);
        add(3'b010, 1'b1, 1'b0, 2'b01, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1);
        add(3'b010, 1'b1, 1'b1, 2'b01, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        // illegal order G->R, then R->G still counts
        add(3'b100, 1'b1, 1'b0, 2'b10, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        add(3'b001, 1'b1, 1'b0, 2'b00, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
        add(3'b100, 1'b1, 1'b0, 2'b10, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0);
        add(3'b001, 1'b1, 1'b0, 2'b00, 1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
        add(3'b001, 1'b1, 1'b1, 2'b00, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        // bad encoding drops lock; relock on yellow without order error
        add(3'b011, 1'b1, 1'b0, 2'b11, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0);
        add(3'b010, 1'b1, 1'b0, 2'b01, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
        // en low: clear still acts, no tracking or detection
        add(3'b001, 1'b0, 1'b1, 2'b01, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        add(3'b100, 1'b0, 1'b0, 2'b01, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        // yellow dwell resumes at 1 -> stall on the 4th extra sample
        add(3'b010, 1'b1, 1'b0, 2'b01, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        add(3'b010, 1'b1, 1'b0, 2'b01, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        add(3'b010, 1'b1, 1'b0, 2'b01, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        add(3'b010, 1'b1, 1'b0, 2'b01, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1);
        // clear and new error on the same edge
        add(3'b110, 1'b1, 1'b1, 2'b11, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0);

        #12;
        check_all("reset", 2'b11, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].lights, vq[i].en, vq[i].clr);
            check_all($sformatf("vec%0d", i), vq[i].ph, vq[i].sy, vq[i].cnt,
                      vq[i].oh, vq[i].od, vq[i].st);
        end

        // Fresh reset, then five full cycles: CNT_W=2 counter wraps to 01.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(3'b100, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(3'b001, 1'b1, 1'b0);
            if (k < 4) begin
                step(3'b010, 1'b1, 1'b0);
                step(3'b100, 1'b1, 1'b0);
            end
        end
        chk("wrap w_count", 32'(w_cnt), 32'd1);
        chk("wrap a_count", 32'(a_cnt), 32'd5);
        chk("wrap w_any",   32'(w_any), 32'd0);
        step(3'b100, 1'b1, 1'b0);
        check_all("pre_rst", 2'b10, 1'b1, 8'd5, 1'b0, 1'b1, 1'b0);

        // Reset between edges must act without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 2'b11, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("async_rst w_synced", 32'(w_synced), 32'd0);
        chk("async_rst w_order",  32'(w_order),  32'd0);
        chk("async_rst w_onehot", 32'(w_onehot), 32'd0);
        chk("async_rst w_stall",  32'(w_stall),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
